// File: rtl/ft_tx_ctrl.sv
// ft_tx_ctrl: streams bytes from the ADC read-side FIFO into the FT232H
// synchronous FIFO write port (ADBUS / WR# / TXE#), clocked by CLKOUT.
//
// Data path: normal-mode FIFO read (data valid one cycle after fifo_rdreq),
// an output register driving ADBUS/WR#, and a 2-entry skid buffer that
// absorbs reads already in flight when TXE# deasserts. Order is strictly FIFO.
//
// Optional feature: define FT_SIWU_EN to build the send-immediate FSM, which
// pulses SIWU# low for one cycle after IDLE_TIMEOUT idle cycles that follow a
// burst. Without FT_SIWU_EN, ft_siwu_n is tied high and the data path is
// unchanged.
//
// Handshake: the output register is the "valid" side (out_valid_q, shown as
// WR# low) and ~ft_txe_i is the "ready" side. A byte transfers at a rising
// edge where both are true; while valid is high and ready is low, ADBUS and
// WR# hold their values. Once valid is raised it is never withdrawn before
// the transfer (except by rst).
`timescale 1ns/1ps

module ft_tx_ctrl #(
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic       ft_shift_clk,
  input  logic       rst,
  input  logic [7:0] fifo_q,
  input  logic       fifo_empty,
  output logic       fifo_rdreq,
  input  logic       ft_txe_i,
  output logic [7:0] ft_adbus_o,
  output logic       ft_wr_n,
  output logic       ft_rd_n,
  output logic       ft_oe_n,
  output logic       ft_siwu_n,
  output logic       busy,
  output logic [1:0] fsm_state_o
);

  // The idle counter compares against IDLE_TIMEOUT-1, so it must be >= 2.
  if (IDLE_TIMEOUT < 2) begin : g_bad_timeout
    $error("ft_tx_ctrl: IDLE_TIMEOUT must be at least 2");
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_data_q,  out_data_d;
  logic [7:0] buf0_q,      buf0_d;      // skid buffer head
  logic [7:0] buf1_q,      buf1_d;      // skid buffer second entry
  logic [1:0] buf_count_q, buf_count_d; // 0..2
  logic       rd_q;                     // a FIFO read returns data this cycle

  // ---------------------------------------------------------------------
  // Handshake and data-path control
  // ---------------------------------------------------------------------
  logic       accept;    // byte taken by the FT232H at this edge
  logic       out_load;  // output register is free to load at this edge
  logic       pop;       // buffer head moves to the output register
  logic       bypass;    // returning fifo_q goes straight to the output reg
  logic       push;      // returning fifo_q goes to the buffer tail
  logic [2:0] occ_next;  // buffer occupancy committed after this edge

  assign accept   = out_valid_q & ~ft_txe_i;
  assign out_load = ~out_valid_q | accept;
  assign pop      = out_load & (buf_count_q != 2'd0);
  assign bypass   = out_load & (buf_count_q == 2'd0) & rd_q;
  assign push     = rd_q & ~bypass;

  // Reads issued now land in the buffer next cycle at worst, so only request
  // while the committed occupancy leaves room for one more entry.
  assign occ_next   = {1'b0, buf_count_q} + {2'b00, rd_q} - {2'b00, pop};
  assign fifo_rdreq = ~fifo_empty & ~rst & (occ_next <= 3'd1);

  assign ft_adbus_o = out_data_q;
  assign ft_wr_n    = ~out_valid_q;
  assign ft_rd_n    = 1'b1;
  assign ft_oe_n    = 1'b1;
  assign busy       = out_valid_q | (buf_count_q != 2'd0) | rd_q;

  // Next-state for the output register and the skid buffer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    buf0_d      = buf0_q;
    buf1_d      = buf1_q;
    buf_count_d = buf_count_q;

    if (out_load) begin
      if (pop) begin
        out_valid_d = 1'b1;
        out_data_d  = buf0_q;
      end else if (rd_q) begin
        out_valid_d = 1'b1;
        out_data_d  = fifo_q;
      end else begin
        out_valid_d = 1'b0;
      end
    end

    case ({push, pop})
      2'b10: begin
        // Write at the tail; the read throttle keeps count below 2 here.
        if (buf_count_q == 2'd0) begin
          buf0_d      = fifo_q;
          buf_count_d = 2'd1;
        end else if (buf_count_q == 2'd1) begin
          buf1_d      = fifo_q;
          buf_count_d = 2'd2;
        end
      end
      2'b01: begin
        buf0_d      = buf1_q;
        buf_count_d = buf_count_q - 2'd1;
      end
      2'b11: begin
        // Head leaves, new byte enters the tail; count is unchanged.
        if (buf_count_q == 2'd1) begin
          buf0_d = fifo_q;
        end else begin
          buf0_d = buf1_q;
          buf1_d = fifo_q;
        end
      end
      default: ;
    endcase
  end

  // Data-path registers; reset drops every held or in-flight byte.
  always_ff @(posedge ft_shift_clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      buf0_q      <= 8'h00;
      buf1_q      <= 8'h00;
      buf_count_q <= 2'd0;
      rd_q        <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      buf_count_q <= buf_count_d;
      rd_q        <= fifo_rdreq;
    end
  end

`ifdef FT_SIWU_EN
  // ---------------------------------------------------------------------
  // Send-immediate FSM: after a burst drains, count idle cycles and flush
  // the FT232H buffer with a one-cycle SIWU# pulse unless new data arrives.
  // ---------------------------------------------------------------------
  localparam int CNT_W = $clog2(IDLE_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_WAIT   = 2'd2,
    ST_SIWU   = 2'd3
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   idle_cnt_q;
  logic               siwu_n_q;

  // FSM, idle counter and registered SIWU# in one process.
  always_ff @(posedge ft_shift_clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idle_cnt_q <= '0;
      siwu_n_q   <= 1'b1;
    end else begin
      siwu_n_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (accept) state_q <= ST_STREAM;
        end
        ST_STREAM: begin
          if (!busy) begin
            state_q    <= ST_WAIT;
            idle_cnt_q <= '0;
          end
        end
        ST_WAIT: begin
          if (fifo_rdreq) begin
            state_q <= ST_STREAM;
          end else if (idle_cnt_q == CNT_W'(IDLE_TIMEOUT - 1)) begin
            state_q  <= ST_SIWU;
            siwu_n_q <= 1'b0;
          end else if (idle_cnt_q != {CNT_W{1'b1}}) begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
          end
        end
        ST_SIWU: begin
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ft_siwu_n   = siwu_n_q;
  assign fsm_state_o = state_q;
`else
  // No send-immediate support: SIWU# idles high, state reads as idle.
  assign ft_siwu_n   = 1'b1;
  assign fsm_state_o = 2'd0;
`endif

endmodule
